// File: rtl/l5_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each access runs IDLE -> WRITE/READ -> DONE; all outputs come straight from flops.
module l5_ram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic [7:0]  ram_a,
    output logic        ram_cs,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_port;
    logic [1:0]  r_cnt;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic [31:0] r_rdata;
    logic [7:0]  r_ram_a;
    logic        r_ram_cs;
    logic        r_ram_oe;
    logic        r_ram_we;
    logic [31:0] r_ram_di;

    logic        w_take;
    logic        w_win;
    logic        w_wr;
    logic [7:0]  w_addr;
    logic [31:0] w_wdata;

    // On contention the port that did not win last time takes the grant.
    always_comb begin
        w_next  = r_state;
        w_take  = 1'b0;
        w_win   = (req0 && req1) ? ~r_last : req1;
        w_wr    = w_win ? wr1 : wr0;
        w_addr  = w_win ? addr1 : addr0;
        w_wdata = w_win ? wdata1 : wdata0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_take = 1'b1;
                    w_next = w_wr ? WRITE : READ;
                end
            end
            WRITE: w_next = DONE;
            READ: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are computed from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_port   <= 1'b0;
            r_cnt    <= 2'd0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata  <= 32'd0;
            r_ram_a  <= 8'd0;
            r_ram_cs <= 1'b0;
            r_ram_oe <= 1'b0;
            r_ram_we <= 1'b0;
            r_ram_di <= 32'd0;
        end else begin
            r_state  <= w_next;
            r_gnt0   <= w_take && !w_win;
            r_gnt1   <= w_take && w_win;
            r_done0  <= (r_state != DONE) && (w_next == DONE) && !r_port;
            r_done1  <= (r_state != DONE) && (w_next == DONE) && r_port;
            r_ram_cs <= (w_next == WRITE) || (w_next == READ);
            r_ram_we <= (w_next == WRITE);
            r_ram_oe <= (w_next == READ);
            if (w_take) begin
                r_last  <= w_win;
                r_port  <= w_win;
                r_cnt   <= 2'd0;
                r_ram_a <= w_addr;
                if (w_wr) begin
                    r_ram_di <= w_wdata;
                end
            end
            if (r_state == READ) begin
                r_cnt <= r_cnt + 2'd1;
                if (w_next == DONE) begin
                    r_rdata <= ram_dout;
                end
            end
        end
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign done0  = r_done0;
    assign done1  = r_done1;
    assign rdata  = r_rdata;
    assign ram_a  = r_ram_a;
    assign ram_cs = r_ram_cs;
    assign ram_oe = r_ram_oe;
    assign ram_we = r_ram_we;
    assign ram_di = r_ram_di;

endmodule

// File: tb/tb_l5_ram_arbiter.sv
// Bench for l5_ram_arbiter: RD_LAT=1 instance for most checks, RD_LAT=3 instance for long reads.
// Completions are matched against a scoreboard queue filled as requests are driven.
module tb_l5_ram_arbiter;

    localparam int RD_LAT = 1;

    typedef struct {
        bit          port;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] expRd;
    } vec_t;

    typedef struct {
        bit          port;
        bit          isRd;
        logic [31:0] rd;
    } sb_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req0, req1, wr0, wr1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;

    logic        gnt0, gnt1, done0, done1;
    logic [31:0] rdata, ramDi, ramDout;
    logic [7:0]  ramA;
    logic        ramCs, ramOe, ramWe;

    logic        gnt0L3, gnt1L3, done0L3, done1L3;
    logic [31:0] rdataL3, ramDiL3, ramDoutL3;
    logic [7:0]  ramAL3;
    logic        ramCsL3, ramOeL3, ramWeL3;

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];

    int          nChecks = 0;
    int          nFails  = 0;
    bit          sbOn    = 1'b0;
    logic [31:0] expLastRd = 32'd0;
    sb_t         sbq [$];
    vec_t        vecs [14];

    always #5 clk = ~clk;

    l5_ram_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rstN),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .ram_a(ramA), .ram_cs(ramCs), .ram_oe(ramOe),
        .ram_we(ramWe), .ram_di(ramDi), .ram_dout(ramDout)
    );

    l5_ram_arbiter #(.RD_LAT(3)) dutL3 (
        .clk(clk), .rst_n(rstN),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0L3), .gnt1(gnt1L3), .done0(done0L3), .done1(done1L3),
        .rdata(rdataL3), .ram_a(ramAL3), .ram_cs(ramCsL3), .ram_oe(ramOeL3),
        .ram_we(ramWeL3), .ram_di(ramDiL3), .ram_dout(ramDoutL3)
    );

    always @(posedge clk) begin
        if (ramCs && ramWe) mem1[ramA] <= ramDi;
        if (ramCsL3 && ramWeL3) mem3[ramAL3] <= ramDiL3;
    end
    assign ramDout   = mem1[ramA];
    assign ramDoutL3 = mem3[ramAL3];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (sbOn && rstN && (done0 || done1)) begin
            sb_t e;
            if (sbq.size() == 0) begin
                checkOutput("sbUnexpectedDone", {30'd0, done1, done0}, 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("donePort", {30'd0, done1, done0}, e.port ? 32'd2 : 32'd1);
                if (e.isRd) begin
                    checkOutput("readData", rdata, e.rd);
                    expLastRd = e.rd;
                end else begin
                    checkOutput("rdataHeldOnWrite", rdata, expLastRd);
                end
            end
        end
    end

    task automatic resetDut();
        @(negedge clk);
        rstN = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = 8'd0; addr1 = 8'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        sbq.delete();
        expLastRd = 32'd0;
    endtask

    // One request on one port; the command is scrambled in the gnt cycle so a late change would show.
    task automatic applyStimulus(input bit port, input bit wr, input logic [7:0] a,
                                 input logic [31:0] d, input logic [31:0] expRd);
        int cyc = 0;
        int csCnt = 0;
        bit gotGnt = 0;
        bit gotDone = 0;
        @(negedge clk);
        if (port) begin
            req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d;
        end
        sbq.push_back('{port, !wr, expRd});
        while (!gotDone && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ramCs) begin
                csCnt++;
                checkOutput("ramAddr", {24'd0, ramA}, {24'd0, a});
                checkOutput("ramStrobes", {30'd0, ramWe, ramOe}, wr ? 32'd2 : 32'd1);
                if (wr) checkOutput("ramWriteData", ramDi, d);
            end
            if (!gotGnt && (port ? gnt1 : gnt0)) begin
                gotGnt = 1'b1;
                checkOutput("gntCycle", cyc, 32'd1);
                if (port) begin
                    req1 = 1'b0; addr1 = ~a; wdata1 = ~d;
                end else begin
                    req0 = 1'b0; addr0 = ~a; wdata0 = ~d;
                end
            end
            if (port ? done1 : done0) gotDone = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput("latency", cyc, wr ? 32'd2 : 32'(RD_LAT + 1));
        checkOutput("csCycles", csCnt, wr ? 32'd1 : 32'(RD_LAT));
    endtask

    initial begin
        int gPort [4];
        int gCyc  [4];
        int nG;
        int cyc;
        int csCnt;
        int oeCnt;
        bit gotDone;

        vecs[0]  = '{1'b0, 1'b1, 8'h3F, 32'h3F3F_0001, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'h40, 32'h4040_0002, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'h7F, 32'h7F7F_0003, 32'd0};
        vecs[3]  = '{1'b1, 1'b1, 8'h80, 32'h8080_0004, 32'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'hBF, 32'hBFBF_0005, 32'd0};
        vecs[5]  = '{1'b1, 1'b1, 8'hC0, 32'hC0C0_0006, 32'd0};
        vecs[6]  = '{1'b0, 1'b1, 8'hFF, 32'hFFFF_0007, 32'd0};
        vecs[7]  = '{1'b1, 1'b0, 8'h3F, 32'd0, 32'h3F3F_0001};
        vecs[8]  = '{1'b0, 1'b0, 8'h40, 32'd0, 32'h4040_0002};
        vecs[9]  = '{1'b1, 1'b0, 8'h7F, 32'd0, 32'h7F7F_0003};
        vecs[10] = '{1'b0, 1'b0, 8'h80, 32'd0, 32'h8080_0004};
        vecs[11] = '{1'b1, 1'b0, 8'hBF, 32'd0, 32'hBFBF_0005};
        vecs[12] = '{1'b0, 1'b0, 8'hC0, 32'd0, 32'hC0C0_0006};
        vecs[13] = '{1'b1, 1'b0, 8'hFF, 32'd0, 32'hFFFF_0007};

        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'd0;
            mem3[i] = 32'd0;
        end

        rstN = 1'b1;
        resetDut();
        @(negedge clk);
        checkOutput("rstCtrl", {25'd0, gnt0, gnt1, done0, done1, ramCs, ramOe, ramWe}, 32'd0);
        checkOutput("rstRamA", {24'd0, ramA}, 32'd0);
        checkOutput("rstRamDi", ramDi, 32'd0);
        checkOutput("rstRdata", rdata, 32'd0);

        // Both ports hold requests: expect 0,1,0,1 with one IDLE cycle between accesses.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h00; wdata0 = 32'h0000_AAAA;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 8'hC0; wdata1 = 32'h0000_BBBB;
        nG = 0;
        cyc = 0;
        while (nG < 4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (gnt0 && nG < 4) begin gPort[nG] = 0; gCyc[nG] = cyc; nG++; end
            if (gnt1 && nG < 4) begin gPort[nG] = 1; gCyc[nG] = cyc; nG++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput("contentionGrants", nG, 32'd4);
        for (int i = 0; i < nG; i++) begin
            checkOutput("contentionPort", gPort[i], 32'(i % 2));
            checkOutput("contentionCycle", gCyc[i], 32'(1 + 3 * i));
        end
        repeat (3) @(negedge clk);
        checkOutput("contentionMem0", mem1[0], 32'h0000_AAAA);
        checkOutput("contentionMemC0", mem1[8'hC0], 32'h0000_BBBB);

        sbOn = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h45, 32'hDEAD_BEEF, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h45, 32'd0, 32'hDEAD_BEEF);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].expRd);
        end
        repeat (2) @(negedge clk);
        checkOutput("sbDrained", sbq.size(), 32'd0);

        // Abort a read with reset in its first READ cycle; rdata is nonzero beforehand.
        applyStimulus(1'b0, 1'b1, 8'h20, 32'h1234_5678, 32'd0);
        sbOn = 1'b0;
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h20;
        @(negedge clk);
        checkOutput("abortInRead", {29'd0, gnt0, ramCs, ramOe}, 32'd7);
        req0 = 1'b0;
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("abortStrobes", {29'd0, ramCs, ramOe, ramWe}, 32'd0);
        checkOutput("abortDone", {30'd0, done0, done1}, 32'd0);
        checkOutput("abortRdata", rdata, 32'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abortNoLateDone", {30'd0, done0, done1}, 32'd0);
        end
        checkOutput("abortRdataHeld", rdata, 32'd0);

        // Long read on the RD_LAT=3 instance.
        resetDut();
        sbOn = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h10, 32'hCAFE_F00D, 32'd0);
        sbOn = 1'b0;
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h10;
        cyc = 0;
        csCnt = 0;
        oeCnt = 0;
        gotDone = 1'b0;
        while (!gotDone && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ramCsL3) csCnt++;
            if (ramOeL3) oeCnt++;
            if (gnt0L3) req0 = 1'b0;
            if (done0L3) gotDone = 1'b1;
        end
        req0 = 1'b0;
        checkOutput("lat3Latency", cyc, 32'd4);
        checkOutput("lat3CsCycles", csCnt, 32'd3);
        checkOutput("lat3OeCycles", oeCnt, 32'd3);
        checkOutput("lat3Rdata", rdataL3, 32'hCAFE_F00D);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
